// File: rtl/fp_subtractor.sv
// -----------------------------------------------------------------------------
// fp_subtractor
//
// Multi-cycle IEEE-754-format floating-point subtractor: Diff = A - B.
// The subtrahend's sign is flipped on accept, so the rest of the datapath is
// an ordinary sign-magnitude adder. Operands are swapped so the larger
// magnitude (X) always sits on the left. The smaller one (Y) is aligned one
// bit per cycle. The magnitudes are then added or subtracted, and the result
// is normalized one bit per cycle.
//
// Denormal operands (exp == 0) are flushed to zero. An exponent of all-ones
// is treated as an ordinary value; there is no NaN propagation.
//
// Optional build macro:
//   FPSUB_ROUND_EN - widens the mantissa path by guard/round/sticky bits and
//                    adds a round-to-nearest-even ROUND state after NORM.
//                    When undefined, the result is truncated.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any in-flight operation
//   in_valid   A/B valid
//   in_ready   operands can be accepted (only in IDLE)
//   A          minuend    {sign, exp[EXP_W], man[MAN_W]}
//   B          subtrahend, same format
//   out_valid  Diff valid; held until out_ready
//   out_ready  consumer accepts Diff
//   Diff       result A - B
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module fp_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         busy
);

    localparam int EXP_W = N / 4;
    localparam int MAN_W = N - N / 4 - 1;
`ifdef FPSUB_ROUND_EN
    localparam int GRS_W = 3;
`else
    localparam int GRS_W = 0;
`endif
    // Mantissa path: carry bit, hidden bit, fraction, optional G/R/S bits.
    localparam int MW    = MAN_W + 2 + GRS_W;
    localparam int HID   = MAN_W + GRS_W;
    localparam int CARRY = MAN_W + 1 + GRS_W;
    // Shifting past the whole mantissa changes nothing more, so clamp there.
    localparam int DMAX  = MAN_W + 2;
    localparam int CNT_W = $clog2(DMAX + 1);
    // One extra exponent bit so an increment past all-ones is still visible.
    localparam int EW    = EXP_W + 1;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_SUB   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             eff_sub_q, eff_sub_d;
    logic             zero_q, zero_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [MW-1:0]    mx_q, mx_d;
    logic [MW-1:0]    my_q, my_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     short_q, short_d;
    logic [N-1:0]     diff_q, diff_d;

    // ---------------------------------------------------------------------
    // Accept-side decode: field split, zero detect, swap, gap clamp.
    // ---------------------------------------------------------------------
    logic             a_sign, b_sign_eff;
    logic [EXP_W-1:0] a_exp, b_exp, exp_x, exp_y, exp_gap;
    logic [MAN_W-1:0] a_man, b_man, man_x, man_y;
    logic             a_zero, b_zero, a_is_x, sign_x, sign_y;
    logic [CNT_W-1:0] gap_clamped;
    logic [MW-1:0]    mx_init, my_init;
    logic [N-1:0]     short_res;

    assign a_sign     = A[N-1];
    assign b_sign_eff = ~B[N-1];
    assign a_exp      = A[N-2:MAN_W];
    assign b_exp      = B[N-2:MAN_W];
    assign a_man      = A[MAN_W-1:0];
    assign b_man      = B[MAN_W-1:0];
    assign a_zero     = (a_exp == '0);
    assign b_zero     = (b_exp == '0);

    // Larger exponent wins; equal exponents fall back to the mantissa.
    assign a_is_x = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));
    assign sign_x = a_is_x ? a_sign : b_sign_eff;
    assign sign_y = a_is_x ? b_sign_eff : a_sign;
    assign exp_x  = a_is_x ? a_exp : b_exp;
    assign exp_y  = a_is_x ? b_exp : a_exp;
    assign man_x  = a_is_x ? a_man : b_man;
    assign man_y  = a_is_x ? b_man : a_man;

    assign exp_gap     = exp_x - exp_y;
    assign gap_clamped = (exp_gap > EXP_W'(DMAX)) ? CNT_W'(DMAX) : exp_gap[CNT_W-1:0];

    // Hidden 1 restored; G/R/S bits (if any) start at zero.
    assign mx_init = MW'({2'b01, man_x}) << GRS_W;
    assign my_init = MW'({2'b01, man_y}) << GRS_W;

    // Zero-operand shortcut result. A zero/denormal A with a zero B gives +0.
    assign short_res = b_zero ? (a_zero ? '0 : A) : {b_sign_eff, B[N-2:0]};

    // ---------------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------------
    logic [EW-1:0] exp_inc, exp_dec;
    logic [MW-1:0] mx_shr, my_shr;
    logic [N-1:0]  packed_res, inf_res;

    assign exp_inc = exp_q + 1'b1;
    assign exp_dec = exp_q - 1'b1;

`ifdef FPSUB_ROUND_EN
    // Bits shifted out of the bottom collapse into the sticky bit.
    assign mx_shr = {1'b0, mx_q[MW-1:2], mx_q[1] | mx_q[0]};
    assign my_shr = {1'b0, my_q[MW-1:2], my_q[1] | my_q[0]};
`else
    assign mx_shr = mx_q >> 1;
    assign my_shr = my_q >> 1;
`endif

    assign packed_res = {sign_q, exp_q[EXP_W-1:0], mx_q[HID-1:GRS_W]};
    assign inf_res    = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

`ifdef FPSUB_ROUND_EN
    logic          round_up;
    logic [MW-1:0] mx_rnd;
    logic [N-1:0]  packed_rnd;

    // Round to nearest, ties to even: bit 3 is the result LSB.
    assign round_up   = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
    assign mx_rnd     = ((mx_q >> 3) + MW'(round_up)) << 3;
    assign packed_rnd = {sign_q, exp_q[EXP_W-1:0], mx_rnd[HID-1:GRS_W]};
`endif

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            zero_q    <= 1'b0;
            exp_q     <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            cnt_q     <= '0;
            short_q   <= '0;
            diff_q    <= '0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            zero_q    <= zero_d;
            exp_q     <= exp_d;
            mx_q      <= mx_d;
            my_q      <= my_d;
            cnt_q     <= cnt_d;
            short_q   <= short_d;
            diff_q    <= diff_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath update
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        zero_d    = zero_q;
        exp_d     = exp_q;
        mx_d      = mx_q;
        my_d      = my_q;
        cnt_d     = cnt_q;
        short_d   = short_q;
        diff_d    = diff_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d    = sign_x;
                    eff_sub_d = (sign_x != sign_y);
                    zero_d    = a_zero | b_zero;
                    exp_d     = {1'b0, exp_x};
                    mx_d      = mx_init;
                    my_d      = my_init;
                    cnt_d     = gap_clamped;
                    short_d   = short_res;
                    state_d   = S_ALIGN;
                end
            end

            S_ALIGN: begin
                if (zero_q) begin
                    diff_d  = short_q;
                    state_d = S_DONE;
                end else if (cnt_q != '0) begin
                    my_d  = my_shr;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_SUB;
                end
            end

            S_SUB: begin
                // The swap guarantees X >= Y, so the difference never wraps.
                mx_d    = eff_sub_q ? (mx_q - my_q) : (mx_q + my_q);
                state_d = S_NORM;
            end

            S_NORM: begin
                if (mx_q == '0) begin
                    diff_d  = '0;
                    state_d = S_DONE;
                end else if (mx_q[CARRY]) begin
                    mx_d  = mx_shr;
                    exp_d = exp_inc;
                    if (exp_inc >= EXP_MAX) begin
                        diff_d  = inf_res;
                        state_d = S_DONE;
                    end
                end else if (mx_q[HID]) begin
`ifdef FPSUB_ROUND_EN
                    state_d = S_ROUND;
`else
                    diff_d  = packed_res;
                    state_d = S_DONE;
`endif
                end else begin
                    mx_d  = mx_q << 1;
                    exp_d = exp_dec;
                    if (exp_dec == '0) begin
                        diff_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end

`ifdef FPSUB_ROUND_EN
            S_ROUND: begin
                // A carry out of rounding leaves exactly 10.00..0; shift it
                // back and come round once more (the second pass never rounds).
                if (mx_rnd[CARRY]) begin
                    mx_d  = {1'b0, mx_rnd[MW-1:1]};
                    exp_d = exp_inc;
                    if (exp_inc >= EXP_MAX) begin
                        diff_d  = inf_res;
                        state_d = S_DONE;
                    end
                end else begin
                    diff_d  = packed_rnd;
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        Diff      = diff_q;
    end

endmodule

// File: tb/tb_fp_subtractor.sv
// -----------------------------------------------------------------------------
// tb_fp_subtractor
//
// Scoreboard bench for fp_subtractor (default truncating build, N = 32).
// The driver pushes the expected Diff and latency for every accepted
// operation; an independent monitor pops and compares whenever out_valid
// rises, and checks that Diff stays put while the consumer back-pressures.
// Expected values come from directed constants or from a plain-arithmetic
// reference model of A - B.
// -----------------------------------------------------------------------------
module tb_fp_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Diff;
    logic        busy;

    fp_subtractor #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    // 0 = random out_ready, 1 = always ready, 2 = never ready
    int rdy_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: sign-magnitude arithmetic on integers, one loop pass per
    // normalize cycle.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] diff, output int lat);
        logic   sa, sb, sx, sy, fin;
        int     ea, eb, ex, ey, d, e, ncyc;
        longint ma, mb, mx, my, m;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = longint'(a[22:0]) + (longint'(1) << 23);
        mb = longint'(b[22:0]) + (longint'(1) << 23);
        diff = 32'h0;
        lat  = 2;
        if (eb == 0) begin
            diff = (ea == 0) ? 32'h0 : a;
        end else if (ea == 0) begin
            diff = {sb, b[30:0]};
        end else begin
            if (ea > eb || (ea == eb && ma >= mb)) begin
                sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
            end else begin
                sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
            end
            d = ex - ey;
            if (d > 25) d = 25;
            my = my >> d;
            m  = (sx == sy) ? mx + my : mx - my;
            e  = ex;
            ncyc = 0;
            fin  = 1'b0;
            while (!fin) begin
                ncyc++;
                if (m == 0) begin
                    diff = 32'h0;
                    fin  = 1'b1;
                end else if (m >= (longint'(1) << 24)) begin
                    m = m >> 1;
                    e = e + 1;
                    if (e >= 255) begin
                        diff = {sx, 8'hFF, 23'h0};
                        fin  = 1'b1;
                    end
                end else if (m >= (longint'(1) << 23)) begin
                    diff = {sx, e[7:0], m[22:0]};
                    fin  = 1'b1;
                end else begin
                    m = m << 1;
                    e = e - 1;
                    if (e == 0) begin
                        diff = 32'h0;
                        fin  = 1'b1;
                    end
                end
            end
            // accept -> ALIGN (d+1) -> SUB (1) -> NORM (ncyc) -> DONE
            lat = d + ncyc + 3;
        end
    endfunction

    // Present operands and wait (bounded) for the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] xd, input int xl);
        exp_t e;
        int   t;
        @(posedge clk);
        #1;
        A = a;
        B = b;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 400);
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 400 cycles");
            in_valid = 1'b0;
        end else begin
            e.a = a; e.b = b; e.diff = xd; e.acc = cyc; e.lat = xl;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sb_q.size() != 0 || !in_ready) && t < 600);
        if (sb_q.size() != 0 || !in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, in_ready=%0d, expected 0 pending and 1",
                     sb_q.size(), in_ready);
        end
    endtask

    // out_ready driver: changes just after the active edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop on each new result, check hold while stalled.
    initial begin
        logic        pv, pr;
        logic [31:0] pd;
        exp_t        e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && (!pv || pr)) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL spurious_valid: Diff=%h appeared, expected no result pending", Diff);
                    end else begin
                        e = sb_q.pop_front();
                        n_txn++;
                        $display("txn %0d: A=%h B=%h Diff=%h (exp %h) latency=%0d (exp %0d)",
                                 n_txn, e.a, e.b, Diff, e.diff, cyc - e.acc, e.lat);
                        check("diff", Diff, e.diff);
                        check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end else if (out_valid) begin
                    check("hold_diff", Diff, pd);
                end else if (pv && !pr) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL valid_drop: out_valid=0 without handoff, expected 1");
                end
                pv = out_valid;
                pr = out_ready;
                pd = Diff;
            end else begin
                pv = 1'b0;
                pr = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed cases: A, B, expected Diff, expected latency.
    logic [31:0] dir_a   [7] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                 32'h4B000000, 32'h00000000, 32'h3F800000};
    logic [31:0] dir_b   [7] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h40400000,
                                 32'h3F800000, 32'h3F800000, 32'h00000000};
    logic [31:0] dir_d   [7] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'hC0000000,
                                 32'h4AFFFFFE, 32'hBF800000, 32'h3F800000};
    int          dir_lat [7] = '{5, 4, 5, 5, 28, 2, 2};

    initial begin
        logic [31:0] ra, rb, xd;
        int          xl, r, ea, eb;
        logic [22:0] man_a, man_b;

        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_diff",      Diff,           32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases with the consumer always ready
        for (int i = 0; i < 7; i++) begin
            issue(dir_a[i], dir_b[i], dir_d[i], dir_lat[i]);
        end
        wait_idle();

        // Backpressure: 3.0 - 1.0 held for 10 cycles
        rdy_mode = 2;
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 5);
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!out_valid && t < 50);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_diff",      Diff,           32'h40000000);
        end
        rdy_mode = 1;
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!out_ready && t < 5);
        end
        @(negedge clk);
        check("release_in_ready",  32'(in_ready),  32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_busy",      32'(busy),      32'd0);

        // Reset during ALIGN of 2^23 - 1.0
        issue(32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 28);
        repeat (8) @(negedge clk);
        check("align_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff",      Diff,           32'h0);
        check("midrst_busy",      32'(busy),      32'd0);
        repeat (40) @(negedge clk);

        // Randomized operations against the reference model
        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            r     = int'($urandom_range(0, 99));
            ea    = int'($urandom_range(100, 150));
            eb    = ea + int'($urandom_range(0, 6)) - 3;
            man_a = 23'($urandom);
            man_b = 23'($urandom);
            if (r < 8) begin
                ea = 0;
            end else if (r < 16) begin
                eb = 0;
            end else if (r < 24) begin
                eb = int'($urandom_range(1, 254));
            end else if (r < 28) begin
                ea = int'($urandom_range(250, 255));
                eb = ea - int'($urandom_range(0, 1));
            end else if (r < 40) begin
                eb    = ea;
                man_b = man_a ^ 23'($urandom_range(0, 15));
            end else if (r < 44) begin
                ea = int'($urandom_range(1, 3));
                eb = ea;
            end
            ra = {1'($urandom), ea[7:0], man_a};
            rb = {1'($urandom), eb[7:0], man_b};
            if (r >= 44 && r < 48) rb = ra;
            ref_model(ra, rb, xd, xl);
            issue(ra, rb, xd, xl);
        end

        rdy_mode = 1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
